// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. It synchronises and deglitches the clock and data lines,
// deserialises 11-bit frames, and folds set-2 E0/F0 prefixes into single key events.
module ps2_rx #(
  parameter int unsigned FILTER  = 4,
  parameter int unsigned TIMEOUT = 8192
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_type,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release
);

  localparam int unsigned   CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]        clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FILTER-1:0] clk_sh_q, clk_sh_d, dat_sh_q, dat_sh_d;
  logic              clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic              fall;
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [CW-1:0]     to_cnt_q, to_cnt_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;
  logic [1:0]        err_type_q, err_type_d;
  logic              ext_q, ext_d, rel_q, rel_d;
  logic              key_strobe_q, key_strobe_d;
  logic [7:0]        key_code_q, key_code_d;
  logic              key_ext_q, key_ext_d, key_release_q, key_release_d;

  // A filtered line only moves once the whole shift register agrees on the new level.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};
    clk_sh_d   = {clk_sh_q[FILTER-2:0], clk_sync_q[1]};
    dat_sh_d   = {dat_sh_q[FILTER-2:0], dat_sync_q[1]};
    clk_filt_d = clk_filt_q;
    if (clk_sh_q == '0)      clk_filt_d = 1'b0;
    else if (clk_sh_q == '1) clk_filt_d = 1'b1;
    dat_filt_d = dat_filt_q;
    if (dat_sh_q == '0)      dat_filt_d = 1'b0;
    else if (dat_sh_q == '1) dat_filt_d = 1'b1;
    fall = clk_filt_q & ~clk_filt_d;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    err_type_d = err_type_q;
    unique case (state_q)
      IDLE: if (fall) begin
        if (!dat_filt_d) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          rx_err_d   = 1'b1;
          err_type_d = 2'd2;
        end
      end
      DATA: if (fall) begin
        shift_d[bit_cnt_q] = dat_filt_d;
        bit_cnt_d          = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = dat_filt_d;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (!(^{shift_q, par_q})) begin
          rx_err_d   = 1'b1;
          err_type_d = 2'd1;
        end else if (!dat_filt_d) begin
          rx_err_d   = 1'b1;
          err_type_d = 2'd2;
        end else begin
          rx_valid_d = 1'b1;
          rx_data_d  = shift_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fall in the same cycle restarts the count, so it takes priority over expiry.
    to_cnt_d = '0;
    if (state_q != IDLE && !fall) begin
      if (to_cnt_q == TO_LAST) begin
        rx_err_d   = 1'b1;
        err_type_d = 2'd3;
        state_d    = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    ext_d         = ext_q;
    rel_d         = rel_q;
    key_strobe_d  = 1'b0;
    key_code_d    = key_code_q;
    key_ext_d     = key_ext_q;
    key_release_d = key_release_q;
    if (rx_err_q) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (rx_valid_q) begin
      unique case (rx_data_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: rel_d = 1'b1;
        8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          ext_d = 1'b0;
          rel_d = 1'b0;
        end
        default: begin
          key_strobe_d  = 1'b1;
          key_code_d    = rx_data_q;
          key_ext_d     = ext_q;
          key_release_d = rel_q;
          ext_d         = 1'b0;
          rel_d         = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      clk_sync_q    <= '1;
      dat_sync_q    <= '1;
      clk_sh_q      <= '1;
      dat_sh_q      <= '1;
      clk_filt_q    <= 1'b1;
      dat_filt_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_err_q      <= 1'b0;
      err_type_q    <= '0;
      ext_q         <= 1'b0;
      rel_q         <= 1'b0;
      key_strobe_q  <= 1'b0;
      key_code_q    <= '0;
      key_ext_q     <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      clk_sync_q    <= clk_sync_d;
      dat_sync_q    <= dat_sync_d;
      clk_sh_q      <= clk_sh_d;
      dat_sh_q      <= dat_sh_d;
      clk_filt_q    <= clk_filt_d;
      dat_filt_q    <= dat_filt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_err_q      <= rx_err_d;
      err_type_q    <= err_type_d;
      ext_q         <= ext_d;
      rel_q         <= rel_d;
      key_strobe_q  <= key_strobe_d;
      key_code_q    <= key_code_d;
      key_ext_q     <= key_ext_d;
      key_release_q <= key_release_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_err      = rx_err_q;
  assign err_type    = err_type_q;
  assign key_strobe  = key_strobe_q;
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Scoreboard bench for ps2_rx: frame stimulus pushes expected events with their exact cycle,
// and a negedge monitor pops and compares each rx_valid / rx_err / key_strobe.
module tb_ps2_rx;
  localparam int unsigned FILTER  = 4;
  localparam int unsigned TIMEOUT = 8192;
  localparam int          LAT     = FILTER + 3;
  localparam int          HALF    = 21;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data, key_code;
  logic       rx_valid, rx_err, key_strobe, key_ext, key_release;
  logic [1:0] err_type;

  ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err), .err_type(err_type),
    .key_strobe(key_strobe), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release)
  );

  always #5 clk_sys = ~clk_sys;

  typedef enum int {EV_VALID, EV_ERR, EV_KEY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    logic [1:0] et;
    logic       ext;
    logic       rel;
    int         cyc;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         last_fall = 0;
  logic       m_ext = 1'b0, m_rel = 1'b0;
  logic [7:0] mon_good = 8'h00;
  logic [1:0] mon_et = 2'd0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic void push_ev(ev_kind_t k, logic [7:0] d, logic [1:0] et,
                                  logic e, logic r, int c);
    ev_t ev;
    ev.kind = k; ev.data = d; ev.et = et; ev.ext = e; ev.rel = r; ev.cyc = c;
    exp_q.push_back(ev);
  endfunction

  // Reference model: frame classification plus prefix-folding key decoder.
  function automatic void model_frame(logic [7:0] b, logic par_bad, logic stop, int c);
    if (par_bad) begin
      push_ev(EV_ERR, 8'h00, 2'd1, 1'b0, 1'b0, c);
      m_ext = 1'b0; m_rel = 1'b0;
    end else if (!stop) begin
      push_ev(EV_ERR, 8'h00, 2'd2, 1'b0, 1'b0, c);
      m_ext = 1'b0; m_rel = 1'b0;
    end else begin
      push_ev(EV_VALID, b, 2'd0, 1'b0, 1'b0, c);
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else if (b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
        m_ext = 1'b0; m_rel = 1'b0;
      end else begin
        push_ev(EV_KEY, b, 2'd0, m_ext, m_rel, c + 1);
        m_ext = 1'b0; m_rel = 1'b0;
      end
    end
  endfunction

  task automatic check_ev(input ev_kind_t k);
    ev_t  e;
    logic ok;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", k, cyc);
      return;
    end
    e  = exp_q.pop_front();
    ok = (e.kind == k) && (cyc == e.cyc);
    case (k)
      EV_VALID: ok = ok && (rx_data == e.data) && (err_type == mon_et);
      EV_ERR:   ok = ok && (err_type == e.et) && (rx_data == mon_good);
      default:  ok = ok && (key_code == e.data) && (key_ext == e.ext) && (key_release == e.rel);
    endcase
    if (!ok) begin
      fails++;
      $display("FAIL event_check: got kind=%0d cyc=%0d rx_data=%h err_type=%0d code=%h ext=%b rel=%b; required kind=%0d cyc=%0d data=%h err_type=%0d ext=%b rel=%b (held rx_data=%h err_type=%0d)",
               k, cyc, rx_data, err_type, key_code, key_ext, key_release,
               e.kind, e.cyc, e.data, e.et, e.ext, e.rel, mon_good, mon_et);
    end
    if (e.kind == EV_VALID) mon_good = e.data;
    if (e.kind == EV_ERR) mon_et = e.et;
  endtask

  always @(negedge clk_sys) begin
    if (rx_valid) check_ev(EV_VALID);
    if (rx_err) check_ev(EV_ERR);
    if (key_strobe) check_ev(EV_KEY);
  end

  task automatic clk_bit(input logic d);
    ps2_data = d;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_bad, input logic stop,
                            input int nbits);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      if (i == 10) model_frame(b, par_bad, stop, cyc + HALF + LAT);
      clk_bit(bits[i]);
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events still pending after %0d cycles, required 0",
               exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) @(negedge clk_sys);
    reset_n  = 1'b1;
    m_ext    = 1'b0;
    m_rel    = 1'b0;
    mon_good = 8'h00;
    mon_et   = 2'd0;
    tests++;
    if ({rx_data, rx_valid, rx_err, err_type, key_strobe, key_code, key_ext, key_release} != '0) begin
      fails++;
      $display("FAIL reset_outputs: got rx_data=%h v=%b e=%b et=%0d ks=%b code=%h ext=%b rel=%b, required all 0",
               rx_data, rx_valid, rx_err, err_type, key_strobe, key_code, key_ext, key_release);
    end
  endtask

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    logic [7:0] sp [10];
    logic [7:0] b;
    int         r;
    sp = '{8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE0};

    @(negedge clk_sys);
    do_reset(3);
    repeat (20) @(negedge clk_sys);

    // Short glitch on the clock line must be filtered away.
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk_sys);

    send_frame(8'h1C, 1'b0, 1'b1, 11); drain(100);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h1C, 1'b0, 1'b1, 11); drain(100);
    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11); drain(100);

    send_frame(8'h1C, 1'b1, 1'b1, 11); drain(100);
    send_frame(8'h33, 1'b0, 1'b0, 11); drain(100);
    push_ev(EV_ERR, 8'h00, 2'd2, 1'b0, 1'b0, cyc + HALF + LAT);
    m_ext = 1'b0; m_rel = 1'b0;
    clk_bit(1'b1); drain(100);

    send_frame(8'hE0, 1'b0, 1'b1, 11);
    send_frame(8'h11, 1'b1, 1'b1, 11);
    send_frame(8'h75, 1'b0, 1'b1, 11); drain(100);

    // Clock stops after start + 4 data bits.
    send_frame(8'h6B, 1'b0, 1'b1, 5);
    push_ev(EV_ERR, 8'h00, 2'd3, 1'b0, 1'b0, last_fall + LAT + TIMEOUT);
    m_ext = 1'b0; m_rel = 1'b0;
    drain(TIMEOUT + 200);
    send_frame(8'h29, 1'b0, 1'b1, 11); drain(100);

    send_frame(8'hE0, 1'b0, 1'b1, 11); drain(100);
    send_frame(8'h12, 1'b0, 1'b1, 4);
    do_reset(1);
    repeat (10) @(negedge clk_sys);
    send_frame(8'h5A, 1'b0, 1'b1, 11); drain(100);

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) b = sp[$urandom_range(0, 9)];
      else b = 8'($urandom);
      send_frame(b, r == 0, r != 1, 11);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk_sys);
    end
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
